// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin arbiter driving a strobed memory bus
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_r0_req,
    input  logic        i_r0_we,
    input  logic [31:0] i_r0_addr,
    input  logic [31:0] i_r0_wdata,
    input  logic        i_r1_req,
    input  logic        i_r1_we,
    input  logic [31:0] i_r1_addr,
    input  logic [31:0] i_r1_wdata,
    output logic        o_r0_done,
    output logic [31:0] o_r0_rdata,
    output logic        o_r1_done,
    output logic [31:0] o_r1_rdata,
    output logic [1:0]  o_grant,
    output logic        o_timeout,
    output logic        o_bus_clk,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_data,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_data_ready
);

    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_RELEASE, S_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          owner_q;
    logic          prefer_r1_q;
    logic          abort_q;
    logic          bus_clk_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_data_q;
    logic [1:0]    grant_q;
    logic          done0_q;
    logic          done1_q;
    logic          timeout_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;
    logic          pick_r1;

    // r1 wins when alone, or on a tie when r0 was granted last
    always_comb begin
        pick_r1 = i_r1_req && (!i_r0_req || prefer_r1_q);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            prefer_r1_q <= 1'b0;
            abort_q     <= 1'b0;
            bus_clk_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            grant_q     <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            timeout_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_r0_req || i_r1_req) begin
                        owner_q     <= pick_r1;
                        prefer_r1_q <= !pick_r1;
                        grant_q     <= pick_r1 ? 2'b10 : 2'b01;
                        bus_we_q    <= pick_r1 ? i_r1_we : i_r0_we;
                        bus_addr_q  <= pick_r1 ? i_r1_addr : i_r0_addr;
                        bus_data_q  <= pick_r1 ? i_r1_wdata : i_r0_wdata;
                        bus_clk_q   <= 1'b1;
                        cnt_q       <= '0;
                        abort_q     <= 1'b0;
                        state_q     <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    // a ready arriving on the timeout cycle still counts as success
                    if (i_bus_data_ready) begin
                        bus_clk_q <= 1'b0;
                        if (!bus_we_q) begin
                            if (owner_q) rdata1_q <= i_bus_data;
                            else         rdata0_q <= i_bus_data;
                        end
                        state_q <= S_RELEASE;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        bus_clk_q <= 1'b0;
                        if (!bus_we_q) begin
                            if (owner_q) rdata1_q <= 32'hFFFF_FFFF;
                            else         rdata0_q <= 32'hFFFF_FFFF;
                        end
                        abort_q <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!i_bus_data_ready) state_q <= S_DONE;
                end
                S_DONE: begin
                    done0_q   <= !owner_q;
                    done1_q   <= owner_q;
                    timeout_q <= abort_q;
                    grant_q   <= '0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_r0_done  = done0_q;
    assign o_r1_done  = done1_q;
    assign o_r0_rdata = rdata0_q;
    assign o_r1_rdata = rdata1_q;
    assign o_grant    = grant_q;
    assign o_timeout  = timeout_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed vector bench for bus_arbiter
module tb_bus_arbiter;
    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_r0_req, i_r0_we, i_r1_req, i_r1_we;
    logic [31:0] i_r0_addr, i_r0_wdata, i_r1_addr, i_r1_wdata;
    logic        o_r0_done, o_r1_done, o_timeout, o_bus_clk, o_bus_we;
    logic [31:0] o_r0_rdata, o_r1_rdata, o_bus_addr, o_bus_data;
    logic [1:0]  o_grant;
    logic [31:0] i_bus_data;
    logic        i_bus_data_ready;

    always #5 i_clk = ~i_clk;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_r0_req(i_r0_req), .i_r0_we(i_r0_we), .i_r0_addr(i_r0_addr), .i_r0_wdata(i_r0_wdata),
        .i_r1_req(i_r1_req), .i_r1_we(i_r1_we), .i_r1_addr(i_r1_addr), .i_r1_wdata(i_r1_wdata),
        .o_r0_done(o_r0_done), .o_r0_rdata(o_r0_rdata), .o_r1_done(o_r1_done), .o_r1_rdata(o_r1_rdata),
        .o_grant(o_grant), .o_timeout(o_timeout), .o_bus_clk(o_bus_clk), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_data(o_bus_data),
        .i_bus_data(i_bus_data), .i_bus_data_ready(i_bus_data_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // d: edge count after grant at which ready is driven (-1 never), h: cycles ready held
    typedef struct {
        bit          r;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          d;
        int          h;
        int          exp_clk;
        int          exp_done;
        bit          exp_to;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vecs[8];

    function automatic logic any_out();
        return |{o_r0_done, o_r1_done, o_r0_rdata, o_r1_rdata, o_grant, o_timeout,
                 o_bus_clk, o_bus_we, o_bus_addr, o_bus_data};
    endfunction

    task automatic set_ready(input logic rdy, input logic [31:0] mem);
        i_bus_data_ready = rdy;
        i_bus_data       = rdy ? mem : 32'h0BAD_0BAD;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   e, clk_n, done_e;
        logic to_seen, strobe_ok, pulse_ok;
        logic [1:0] g;
        g = v.r ? 2'b10 : 2'b01;
        @(negedge i_clk);
        if (v.r) begin
            i_r1_req = 1'b1; i_r1_we = v.we; i_r1_addr = v.addr; i_r1_wdata = v.wdata;
        end else begin
            i_r0_req = 1'b1; i_r0_we = v.we; i_r0_addr = v.addr; i_r0_wdata = v.wdata;
        end
        set_ready(v.d == 0 && v.h > 0, v.mem);
        e = 0; clk_n = 0; done_e = -1; to_seen = 1'b0; strobe_ok = 1'b1; pulse_ok = 1'b1;
        while (done_e < 0 && e < 40) begin
            @(negedge i_clk);
            e++;
            if (o_bus_clk) begin
                clk_n++;
                if (o_grant !== g || o_bus_we !== v.we || o_bus_addr !== v.addr ||
                    (v.we && o_bus_data !== v.wdata)) strobe_ok = 1'b0;
            end
            if ($countones(o_grant) > 1 || (o_r0_done && o_r1_done)) pulse_ok = 1'b0;
            if (o_r0_done || o_r1_done) begin
                done_e  = e;
                to_seen = o_timeout;
                if ((v.r ? o_r1_done : o_r0_done) !== 1'b1 || o_grant !== 2'b00) pulse_ok = 1'b0;
                i_r0_req = 1'b0; i_r1_req = 1'b0;
            end else if (o_timeout) begin
                pulse_ok = 1'b0;
            end
            set_ready(v.d >= 0 && e >= v.d && e < v.d + v.h, v.mem);
        end
        i_r0_req = 1'b0; i_r1_req = 1'b0;
        set_ready(1'b0, v.mem);
        @(negedge i_clk);
        if (o_r0_done || o_r1_done || o_timeout) pulse_ok = 1'b0;
        check($sformatf("v%0d_strobe_cycles", idx), 64'(clk_n), 64'(v.exp_clk));
        check($sformatf("v%0d_done_edge", idx), 64'(done_e), 64'(v.exp_done));
        check($sformatf("v%0d_timeout", idx), 64'(to_seen), 64'(v.exp_to));
        check($sformatf("v%0d_strobe_fields", idx), 64'(strobe_ok), 64'd1);
        check($sformatf("v%0d_pulses", idx), 64'(pulse_ok), 64'd1);
        check($sformatf("v%0d_rdata0", idx), 64'(o_r0_rdata), 64'(v.exp_rd0));
        check($sformatf("v%0d_rdata1", idx), 64'(o_r1_rdata), 64'(v.exp_rd1));
    endtask

    initial begin
        logic [1:0] order[4];
        int         n_g, n_done, guard;
        logic       prev_clk, late_done;

        //         r  we addr          wdata         mem           d   h  clk done to rd0           rd1
        vecs[0] = '{0, 0, 32'h0000_1234, 32'h0,        32'hDEAD_BEEF, 2,  1, 2,  5,  0, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1, 1, 32'h0000_0200, 32'h0000_00A5, 32'h1111_1111, 1,  1, 1,  4,  0, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1, 0, 32'h0000_0300, 32'h0,        32'h1234_5678, 1,  1, 1,  4,  0, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{0, 0, 32'h0000_0040, 32'h0,        32'h2222_2222, -1, 0, 5,  8,  1, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[4] = '{0, 1, 32'h0000_0044, 32'h0000_55AA, 32'h3333_3333, 1,  3, 1,  6,  0, 32'hFFFF_FFFF, 32'h1234_5678};
        vecs[5] = '{1, 0, 32'h0000_0048, 32'h0,        32'hCAFE_F00D, 0,  2, 1,  4,  0, 32'hFFFF_FFFF, 32'hCAFE_F00D};
        vecs[6] = '{1, 1, 32'h0000_004C, 32'h0000_0777, 32'h4444_4444, -1, 0, 5,  8,  1, 32'hFFFF_FFFF, 32'hCAFE_F00D};
        vecs[7] = '{0, 0, 32'h0000_0050, 32'h0,        32'h0F0F_0F0F, 5,  1, 5,  8,  0, 32'h0F0F_0F0F, 32'hCAFE_F00D};

        i_rst = 1'b1;
        i_r0_req = 1'b0; i_r0_we = 1'b0; i_r0_addr = '0; i_r0_wdata = '0;
        i_r1_req = 1'b0; i_r1_we = 1'b0; i_r1_addr = '0; i_r1_wdata = '0;
        set_ready(1'b0, 32'h0);
        repeat (3) @(negedge i_clk);
        check("reset_outputs", 64'(any_out()), 64'd0);
        i_rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset while a read strobe is in flight
        @(negedge i_clk);
        i_r0_req = 1'b1; i_r0_we = 1'b0; i_r0_addr = 32'h99;
        repeat (2) @(negedge i_clk);
        check("midrst_strobe_active", 64'(o_bus_clk), 64'd1);
        #2 i_rst = 1'b1;
        #1 check("midrst_outputs_zero", 64'(any_out()), 64'd0);
        i_r0_req = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        late_done = 1'b0;
        repeat (5) begin
            @(negedge i_clk);
            if (o_r0_done || o_r1_done) late_done = 1'b1;
        end
        check("midrst_no_done", 64'(late_done), 64'd0);

        // both requesters held high: strict alternation starting at r0
        i_r0_req = 1'b1; i_r0_we = 1'b0; i_r0_addr = 32'h600;
        i_r1_req = 1'b1; i_r1_we = 1'b1; i_r1_addr = 32'h700; i_r1_wdata = 32'h77;
        n_g = 0; n_done = 0; guard = 0; prev_clk = 1'b0;
        while (n_g < 4 && guard < 60) begin
            @(negedge i_clk);
            guard++;
            if (o_bus_clk && !prev_clk) begin
                order[n_g] = o_grant;
                n_g++;
            end
            if (o_r0_done || o_r1_done) n_done++;
            prev_clk = o_bus_clk;
            set_ready(o_bus_clk, 32'h600D_600D);
        end
        i_r0_req = 1'b0; i_r1_req = 1'b0;
        check("rr_grants_seen", 64'(n_g), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), 64'(order[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        check("rr_done_count", 64'(n_done), 64'd3);
        guard = 0;
        while (!(o_r0_done || o_r1_done) && guard < 20) begin
            @(negedge i_clk);
            guard++;
            set_ready(o_bus_clk, 32'h600D_600D);
        end
        check("rr_last_done_r1", 64'(o_r1_done), 64'd1);
        check("rr_rdata0", 64'(o_r0_rdata), 64'h600D_600D);
        check("rr_rdata1_untouched", 64'(o_r1_rdata), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles o_bus_clk stays high waiting for i_bus_data_ready before abort.
REQ-002 i_clk  input  1  system clock, all state on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_r0_req / i_r1_req  input  1 each  transfer request, requester 0 (CPU) / requester 1 (DMA); held high until matching done.
REQ-005 i_r0_we / i_r1_we  input  1 each  1 = write, 0 = read; valid while req high.
REQ-006 i_r0_addr / i_r1_addr  input  32 each  transfer address.
REQ-007 i_r0_wdata / i_r1_wdata  input  32 each  write data.
REQ-008 o_r0_done / o_r1_done  output  1 each  one-cycle completion pulse.
REQ-009 o_r0_rdata / o_r1_rdata  output  32 each  read data, valid from done pulse until that requester's next done.
REQ-010 o_grant  output  2  one-hot current owner (bit0 = r0, bit1 = r1), 0 when idle.
REQ-011 o_timeout  output  1  one-cycle pulse, coincident with done of an aborted transfer.
REQ-012 o_bus_clk, o_bus_we  output  1 each  memory strobe, write enable.
REQ-013 o_bus_addr, o_bus_data  output  32 each  memory address, write data.
REQ-014 i_bus_data, i_bus_data_ready  input  32, 1  memory read data, memory ready.

Function
REQ-015 Registered FSM with states IDLE, ACTIVE, RELEASE, DONE; all outputs registered.
REQ-016 IDLE: no req -> stay; any req -> select owner, latch owner's we/addr/wdata onto o_bus_we/o_bus_addr/o_bus_data, set o_grant, set o_bus_clk=1, clear timeout counter, go ACTIVE.
REQ-017 Selection: single requester wins; both high -> requester not granted last (round-robin pointer), pointer updates on each grant; after reset r0 wins first tie.
REQ-018 ACTIVE: o_bus_clk=1, addr/data/we stable; counter increments each cycle; i_bus_data_ready=1 -> o_bus_clk=0, if read capture i_bus_data into owner's rdata, go RELEASE.
REQ-019 ACTIVE timeout: counter == TIMEOUT with ready still 0 -> o_bus_clk=0, owner's rdata = 0xFFFFFFFF if read, flag abort, go RELEASE.
REQ-020 RELEASE: wait until i_bus_data_ready=0, then go DONE; no new strobe issued while ready high.
REQ-021 DONE: owner's done=1 for exactly this cycle, o_timeout=1 if aborted, o_grant cleared on exit, go IDLE.
REQ-022 Requests sampled only in IDLE; a requester dropping req while owned does not cancel the transfer.
REQ-023 Minimum latency: grant edge -> done pulse 3 cycles later when ready asserts first ACTIVE cycle and drops next cycle.
REQ-024 Ready high while IDLE is ignored; ready already high on entering ACTIVE completes in 1 cycle.
REQ-025 Counter 8 bits min, sized to hold TIMEOUT, no wrap inside one transfer.
REQ-026 Never more than one o_grant bit or one done pulse per cycle.

Reset
REQ-027 i_rst asserted at any time, including mid-ACTIVE: state IDLE, all outputs 0 (o_bus_clk, o_bus_we, addr, data, grant, done, timeout, both rdata), counter 0, pointer favours r0; in-flight transfer abandoned with no done.

Verification
REQ-028 r0 read addr 0x0000_1234, memory returns 0xDEADBEEF after 2 cycles -> o_bus_clk high 2 cycles, o_bus_we=0, o_r0_rdata=0xDEADBEEF, one o_r0_done pulse, o_grant=01 then 00.
REQ-029 r1 write addr 0x200, data 0xA5 -> o_bus_we=1, o_bus_addr=0x200, o_bus_data=0xA5 during strobe; o_r1_done pulse; o_r1_rdata unchanged.
REQ-030 Both req high continuously after reset -> grant order r0, r1, r0, r1; no back-to-back same owner.
REQ-031 TIMEOUT=4, ready never asserts on read -> o_bus_clk high 5 cycles, o_r0_rdata=0xFFFFFFFF, o_timeout and o_r0_done pulse together.
REQ-032 Ready held high 3 cycles after strobe drop -> done only after ready low; i_rst pulse mid-ACTIVE -> all outputs 0 immediately, no done, next request served normally.
